// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every non-clock/reset signal of the reorder buffer.
//   master : decode/writeback side. Drives alloc_valid and wb_*. Receives
//            alloc_ready/alloc_id, the commit port, the exception port and count.
//   slave  : the reorder buffer itself (the reverse directions).
// Signals
//   alloc_valid / alloc_ready / alloc_id        : entry allocation handshake
//   wb_valid, wb_id, wb_addr, wb_data, wb_we,
//   wb_exc, wb_pc                               : writeback of one entry
//   commit_valid, commit_addr, commit_data,
//   commit_we                                   : registered register-file write
//   exc_valid, exc_pc                           : registered exception/flush
//   count                                       : occupied entries
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int PC_W   = 16
);
    localparam int IDW = $clog2(DEPTH);

    logic              alloc_valid;
    logic              alloc_ready;
    logic [IDW-1:0]    alloc_id;

    logic              wb_valid;
    logic [IDW-1:0]    wb_id;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic              wb_exc;
    logic [PC_W-1:0]   wb_pc;

    logic              commit_valid;
    logic [REG_W-1:0]  commit_addr;
    logic [DATA_W-1:0] commit_data;
    logic              commit_we;

    logic              exc_valid;
    logic [PC_W-1:0]   exc_pc;

    logic [IDW:0]      count;

    modport master (
        output alloc_valid,
        input  alloc_ready, alloc_id,
        output wb_valid, wb_id, wb_addr, wb_data, wb_we, wb_exc, wb_pc,
        input  commit_valid, commit_addr, commit_data, commit_we,
        input  exc_valid, exc_pc,
        input  count
    );

    modport slave (
        input  alloc_valid,
        output alloc_ready, alloc_id,
        input  wb_valid, wb_id, wb_addr, wb_data, wb_we, wb_exc, wb_pc,
        output commit_valid, commit_addr, commit_data, commit_we,
        output exc_valid, exc_pc,
        output count
    );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular buffer of DEPTH in-flight instructions. Decode allocates at the
// tail, out-of-order writebacks mark entries done, and the head entry retires
// in order (at most one per cycle) once it is done. A retiring entry that
// raised an exception flushes the whole buffer.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   rob    : reorder_buffer_if.slave (allocation, writeback, commit,
//            exception and occupancy signals)
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int PC_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    reorder_buffer_if.slave rob
);
    localparam int IDW = $clog2(DEPTH);
    localparam int CW  = IDW + 1;

    // Entry status (reset) and payload (not reset)
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [REG_W-1:0]  addr_q [DEPTH];
    logic [REG_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  we_q, we_d;
    logic [DEPTH-1:0]  exc_q, exc_d;
    logic [PC_W-1:0]   pc_q [DEPTH];
    logic [PC_W-1:0]   pc_d [DEPTH];

    logic [IDW-1:0]    head_q, head_d;
    logic [IDW-1:0]    tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              commit_valid_q, commit_valid_d;
    logic [REG_W-1:0]  commit_addr_q, commit_addr_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic              commit_we_q, commit_we_d;
    logic              exc_valid_q, exc_valid_d;
    logic [PC_W-1:0]   exc_pc_q, exc_pc_d;

    logic retire;
    logic retire_exc;
    logic alloc_fire;
    logic wb_fire;

    assign retire     = busy_q[head_q] && done_q[head_q];
    assign retire_exc = retire && exc_q[head_q];

    // Fullness comes from count alone: head == tail is both empty and full.
    // A pending flush blocks allocation so the new entry is not lost.
    assign rob.alloc_ready = (count_q != CW'(DEPTH)) && !retire_exc;
    assign alloc_fire      = rob.alloc_valid && rob.alloc_ready;
    // Writebacks in the flush cycle target entries that are about to vanish.
    assign wb_fire         = rob.wb_valid && busy_q[rob.wb_id] && !retire_exc;

    assign rob.alloc_id     = tail_q;
    assign rob.count        = count_q;
    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_addr  = commit_addr_q;
    assign rob.commit_data  = commit_data_q;
    assign rob.commit_we    = commit_we_q;
    assign rob.exc_valid    = exc_valid_q;
    assign rob.exc_pc       = exc_pc_q;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        busy_d         = busy_q;
        done_d         = done_q;
        addr_d         = addr_q;
        data_d         = data_q;
        we_d           = we_q;
        exc_d          = exc_q;
        pc_d           = pc_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q + CW'(alloc_fire) - CW'(retire);
        commit_valid_d = 1'b0;
        commit_addr_d  = commit_addr_q;
        commit_data_d  = commit_data_q;
        commit_we_d    = commit_we_q;
        exc_valid_d    = 1'b0;
        exc_pc_d       = exc_pc_q;

        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + IDW'(1);
        end

        // The allocated slot is never busy, so it cannot collide with wb_id.
        if (wb_fire) begin
            done_d[rob.wb_id] = 1'b1;
            addr_d[rob.wb_id] = rob.wb_addr;
            data_d[rob.wb_id] = rob.wb_data;
            we_d[rob.wb_id]   = rob.wb_we;
            exc_d[rob.wb_id]  = rob.wb_exc;
            pc_d[rob.wb_id]   = rob.wb_pc;
        end

        // Retirement reads only registered state: a writeback at edge N is
        // first visible here in the cycle after N.
        if (retire) begin
            commit_valid_d = 1'b1;
            commit_addr_d  = addr_q[head_q];
            commit_data_d  = data_q[head_q];
            commit_we_d    = we_q[head_q] && !exc_q[head_q];
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + IDW'(1);
        end

        if (retire_exc) begin
            exc_valid_d = 1'b1;
            exc_pc_d    = pc_q[head_q];
            busy_d      = '0;
            done_d      = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_addr_q  <= '0;
            commit_data_q  <= '0;
            commit_we_q    <= 1'b0;
            exc_valid_q    <= 1'b0;
            exc_pc_q       <= '0;
        end else begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_addr_q  <= commit_addr_d;
            commit_data_q  <= commit_data_d;
            commit_we_q    <= commit_we_d;
            exc_valid_q    <= exc_valid_d;
            exc_pc_q       <= exc_pc_d;
        end
    end

    // NOTE: payload storage has no reset; it is only read once busy and done
    // (both reset) mark the entry as holding a fresh writeback.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        we_q   <= we_d;
        exc_q  <= exc_d;
        pc_q   <= pc_d;
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed bench for reorder_buffer (DEPTH=8). Stimulus pushes the expected
// commits into a queue; a monitor on the falling edge pops and compares each
// time the DUT raises commit_valid. Cycle-specific properties (readiness,
// occupancy, ids, latency, asynchronous reset) are checked inline.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int PC_W   = 16;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic              we;
        logic              exc;
        logic [PC_W-1:0]   pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   failed = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    reorder_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W)) bus ();

    reorder_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int addr, input int data, input logic we, input logic exc,
                            input int pc);
        exp_t e;
        e.addr = REG_W'(addr);
        e.data = DATA_W'(data);
        e.we   = we;
        e.exc  = exc;
        e.pc   = PC_W'(pc);
        exp_q.push_back(e);
    endtask

    // Monitor: every commit must match the next expected one, in order.
    always @(negedge clk) begin
        if (bus.commit_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_commit: got addr 0x%0h data 0x%0h, expected none at %0t",
                         bus.commit_addr, bus.commit_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_addr", 32'(bus.commit_addr), 32'(mon_e.addr));
                check("commit_data", 32'(bus.commit_data), 32'(mon_e.data));
                check("commit_we",   32'(bus.commit_we),   32'(mon_e.we));
                check("exc_valid",   32'(bus.exc_valid),   32'(mon_e.exc));
                if (mon_e.exc) check("exc_pc", 32'(bus.exc_pc), 32'(mon_e.pc));
            end
        end else if (bus.exc_valid) begin
            tests++;
            failed++;
            $display("FAIL exc_without_commit: got exc_valid 1, expected 0 at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic alloc(input int exp_id);
        bus.alloc_valid = 1'b1;
        check("alloc_ready", 32'(bus.alloc_ready), 1);
        check("alloc_id", 32'(bus.alloc_id), exp_id);
        step();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic wb(input int id, input int addr, input int data, input logic we,
                      input logic exc, input int pc);
        bus.wb_valid = 1'b1;
        bus.wb_id    = 3'(id);
        bus.wb_addr  = REG_W'(addr);
        bus.wb_data  = DATA_W'(data);
        bus.wb_we    = we;
        bus.wb_exc   = exc;
        bus.wb_pc    = PC_W'(pc);
        step();
        bus.wb_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #2;
        check("rst_pulse_count", 32'(bus.count), 0);
        reset = 1'b1;
        step();
    endtask

    initial begin
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_id       = '0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.wb_we       = 1'b0;
        bus.wb_exc      = 1'b0;
        bus.wb_pc       = '0;

        // Reset state
        #2;
        check("rst_count",        32'(bus.count), 0);
        check("rst_commit_valid", 32'(bus.commit_valid), 0);
        check("rst_commit_addr",  32'(bus.commit_addr), 0);
        check("rst_commit_data",  32'(bus.commit_data), 0);
        check("rst_commit_we",    32'(bus.commit_we), 0);
        check("rst_exc_valid",    32'(bus.exc_valid), 0);
        check("rst_exc_pc",       32'(bus.exc_pc), 0);
        check("rst_alloc_ready",  32'(bus.alloc_ready), 1);
        check("rst_alloc_id",     32'(bus.alloc_id), 0);
        #6;
        reset = 1'b1;

        // In-order commit of out-of-order writebacks
        alloc(0);
        alloc(1);
        alloc(2);
        check("io_count3", 32'(bus.count), 3);
        push_exp(1, 16'h0000, 1'b1, 1'b0, 0);
        push_exp(2, 16'h0011, 1'b1, 1'b0, 0);
        push_exp(3, 16'h0022, 1'b1, 1'b0, 0);
        wb(2, 3, 16'h0022, 1'b1, 1'b0, 16'h0008);
        check("io_no_commit_slot2_only", 32'(bus.commit_valid), 0);
        wb(0, 1, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check("io_no_early_commit", 32'(bus.commit_valid), 0);
        wb(1, 2, 16'h0011, 1'b1, 1'b0, 16'h0004);
        check("io_commit_latency", 32'(bus.commit_valid), 1);
        idle(3);
        check("io_count0", 32'(bus.count), 0);

        // Full buffer
        reset_pulse();
        for (int i = 0; i < 8; i++) alloc(i);
        check("full_count8", 32'(bus.count), 8);
        check("full_not_ready", 32'(bus.alloc_ready), 0);
        bus.alloc_valid = 1'b1;
        step();
        bus.alloc_valid = 1'b0;
        check("full_9th_ignored", 32'(bus.count), 8);
        check("full_tail_wrapped", 32'(bus.alloc_id), 0);
        push_exp(5, 16'hA5A5, 1'b1, 1'b0, 0);
        wb(0, 5, 16'hA5A5, 1'b1, 1'b0, 16'h0100);
        check("full_retiring_not_ready", 32'(bus.alloc_ready), 0);
        check("full_retiring_count", 32'(bus.count), 8);
        step();
        check("full_after_retire_count", 32'(bus.count), 7);
        alloc(0);
        check("full_refill_count", 32'(bus.count), 8);

        // Wrap: back-to-back allocate + writeback of the previous slot
        reset_pulse();
        for (int k = 0; k < 20; k++) begin
            bus.alloc_valid = 1'b1;
            if (k > 0) begin
                bus.wb_valid = 1'b1;
                bus.wb_id    = 3'((k - 1) % 8);
                bus.wb_addr  = REG_W'((k - 1) % 8);
                bus.wb_data  = DATA_W'(16'h1000 + k - 1);
                bus.wb_we    = ((k - 1) % 3) != 0;
                bus.wb_exc   = 1'b0;
                bus.wb_pc    = '0;
                push_exp((k - 1) % 8, 16'h1000 + k - 1, ((k - 1) % 3) != 0, 1'b0, 0);
            end
            check("wrap_ready", 32'(bus.alloc_ready), 1);
            check("wrap_alloc_id", 32'(bus.alloc_id), k % 8);
            step();
            check("wrap_count_le2", 32'(bus.count <= 4'd2), 1);
        end
        bus.alloc_valid = 1'b0;
        push_exp(3, 16'h1000 + 19, 1'b0, 1'b0, 0);
        wb(3, 3, 16'h1000 + 19, 1'b0, 1'b0, 0);
        idle(3);
        check("wrap_drained", 32'(bus.count), 0);

        // Exception flush
        reset_pulse();
        for (int i = 0; i < 4; i++) alloc(i);
        push_exp(2, 16'h00A0, 1'b1, 1'b0, 0);
        push_exp(4, 16'hBEEF, 1'b0, 1'b1, 16'h0040);
        wb(1, 4, 16'hBEEF, 1'b1, 1'b1, 16'h0040);
        wb(0, 2, 16'h00A0, 1'b1, 1'b0, 16'h003C);
        check("exc_ready_before", 32'(bus.alloc_ready), 1);
        step();
        check("exc_pending_not_ready", 32'(bus.alloc_ready), 0);
        bus.alloc_valid = 1'b1;
        bus.wb_valid    = 1'b1;
        bus.wb_id       = 3'd2;
        bus.wb_exc      = 1'b0;
        step();
        bus.alloc_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        check("exc_flag", 32'(bus.exc_valid), 1);
        check("exc_pc_value", 32'(bus.exc_pc), 16'h0040);
        check("exc_commit_we", 32'(bus.commit_we), 0);
        check("exc_count0", 32'(bus.count), 0);
        check("exc_next_id", 32'(bus.alloc_id), 0);
        step();
        check("exc_pulse_end", 32'(bus.exc_valid), 0);
        check("commit_pulse_end", 32'(bus.commit_valid), 0);
        check("commit_addr_hold", 32'(bus.commit_addr), 4);
        alloc(0);

        // Asynchronous reset in the middle of a run
        reset_pulse();
        for (int i = 0; i < 5; i++) alloc(i);
        check("ar_count5", 32'(bus.count), 5);
        wb(0, 1, 16'h5555, 1'b1, 1'b0, 0);
        step();
        check("ar_commit_before_reset", 32'(bus.commit_valid), 1);
        #1;
        reset = 1'b0;
        #1;
        check("ar_async_count", 32'(bus.count), 0);
        check("ar_async_commit_valid", 32'(bus.commit_valid), 0);
        check("ar_async_commit_data", 32'(bus.commit_data), 0);
        #1;
        reset = 1'b1;
        step();
        wb(3, 6, 16'h3333, 1'b1, 1'b0, 0);
        idle(2);
        check("ar_stale_wb_count", 32'(bus.count), 0);
        check("ar_first_id", 32'(bus.alloc_id), 0);

        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
